uart_rx_cfg: RTL and testbench

- Parametrised next-generation UART receiver for the FPGA serial link.
- Adds the following over the fixed 8N1 receiver:
  - configurable data width, parity and stop-bit count
  - input synchroniser and 3-sample majority voting
  - parity, framing and break error flags
  - valid/ack output handshake with overrun detection
- Sits between the rxIn pad and the command/decoder logic; one instance per serial channel.

---
 rtl/uart_rx_cfg.sv | 162 ++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 2-flop input synchroniser, 3-sample majority vote per bit,
// parity/frame/break flags and a valid/ack handshake with sticky overrun.
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 6944,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int CNT_W        = 13
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 rxIn,
  input  logic                 rxAck,
  output logic [DATA_BITS-1:0] rxOut,
  output logic                 rxValid,
  output logic                 rxDone,
  output logic                 parityErr,
  output logic                 frameErr,
  output logic                 breakDet,
  output logic                 overrun,
  output logic                 busy
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  localparam logic [CNT_W-1:0] LP_CMAX = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] LP_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] LP_V1   = CNT_W'(CLKS_PER_BIT - 3);
  localparam logic [CNT_W-1:0] LP_V2   = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [CNT_W-1:0] LP_ONE  = CNT_W'(1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [1:0]           r_sync;
  logic [CNT_W-1:0]     r_cnt;
  logic [3:0]           r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_v1;
  logic                 r_v2;
  logic                 r_par;
  logic                 r_fe;
  logic                 r_allz;
  logic                 r_armed;
  logic                 w_rx_s;
  logic                 w_maj;
  logic                 w_tick;
  logic                 w_half;
  logic                 w_done;
  logic                 w_pcalc;
  logic                 w_perr;
  logic                 w_brk;

  function automatic logic f_maj(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  assign w_rx_s  = r_sync[1];
  assign w_maj   = f_maj(r_v1, r_v2, w_rx_s);
  assign w_tick  = (r_cnt == LP_CMAX);
  assign w_half  = (r_cnt == LP_HALF);
  assign w_pcalc = (^r_shift) ^ r_par;
  assign w_perr  = (PARITY == 1) ? ~w_pcalc : ((PARITY == 2) ? w_pcalc : 1'b0);
  // Break includes the first stop bit, which is only decided in this same cycle for 1 stop bit.
  assign w_brk   = r_allz & ((r_idx != 4'd0) | ~w_maj);
  assign busy    = (r_state != S_IDLE);

  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE:   if (!w_rx_s && r_armed) w_state_nxt = S_START;
      S_START:  if (w_half) w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
      S_DATA:   if (w_tick && r_idx == 4'(DATA_BITS - 1))
                  w_state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (w_tick) w_state_nxt = S_STOP;
      S_STOP:   if (w_tick && r_idx == 4'(STOP_BITS - 1)) begin
                  w_state_nxt = S_IDLE;
                  w_done      = 1'b1;
                end
      default:  w_state_nxt = S_IDLE;
    endcase
    if (!en) begin
      w_state_nxt = S_IDLE;
      w_done      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync    <= 2'b11;
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_shift   <= '0;
      r_v1      <= 1'b0;
      r_v2      <= 1'b0;
      r_par     <= 1'b0;
      r_fe      <= 1'b0;
      r_allz    <= 1'b0;
      r_armed   <= 1'b1;
      rxOut     <= '0;
      rxValid   <= 1'b0;
      rxDone    <= 1'b0;
      parityErr <= 1'b0;
      frameErr  <= 1'b0;
      breakDet  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], rxIn};
      r_state <= w_state_nxt;
      rxDone  <= w_done;
      if (w_rx_s) r_armed <= 1'b1;

      if (r_state == S_IDLE || w_state_nxt != r_state || w_tick) r_cnt <= '0;
      else                                                       r_cnt <= r_cnt + LP_ONE;
      if (w_state_nxt != r_state) r_idx <= '0;
      else if (w_tick)            r_idx <= r_idx + 4'd1;

      if (r_cnt == LP_V1) r_v1 <= w_rx_s;
      if (r_cnt == LP_V2) r_v2 <= w_rx_s;

      case (r_state)
        S_START: if (w_half) begin
          r_allz <= 1'b1;
          r_fe   <= 1'b0;
        end
        S_DATA: if (w_tick) begin
          r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
          r_allz  <= r_allz & ~w_maj;
        end
        S_PARITY: if (w_tick) begin
          r_par  <= w_maj;
          r_allz <= r_allz & ~w_maj;
        end
        S_STOP: if (w_tick) begin
          if (!w_maj) r_fe <= 1'b1;
          if (r_idx == 4'd0) r_allz <= r_allz & ~w_maj;
        end
        default: ;
      endcase

      // A completing frame takes priority over a plain ack; ack in the same cycle just cancels overrun.
      if (w_done) begin
        rxOut     <= r_shift;
        parityErr <= w_perr;
        frameErr  <= r_fe | ~w_maj;
        breakDet  <= w_brk;
        rxValid   <= 1'b1;
        overrun   <= (rxValid && rxAck) ? 1'b0 : (overrun | rxValid);
        if (w_brk) r_armed <= 1'b0;
      end else if (rxAck && rxValid) begin
        rxValid   <= 1'b0;
        overrun   <= 1'b0;
        parityErr <= 1'b0;
        frameErr  <= 1'b0;
        breakDet  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: an 8N1 instance and a 7E2 instance, both at 16 clocks per bit.
module tb_uart_rx_cfg;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       rxAck;
  logic       rx8;
  logic       rx7;
  logic [7:0] out8;
  logic       v8, d8, pe8, fe8, bk8, ov8, by8;
  logic [6:0] out7;
  logic       v7, d7, pe7, fe7, bk7, ov7, by7;

  int errors = 0;
  int checks = 0;
  int done8  = 0;
  int done7  = 0;

  uart_rx_cfg #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .CNT_W(5)) u8 (
    .clk(clk), .rst_n(rst_n), .en(en), .rxIn(rx8), .rxAck(rxAck),
    .rxOut(out8), .rxValid(v8), .rxDone(d8), .parityErr(pe8), .frameErr(fe8),
    .breakDet(bk8), .overrun(ov8), .busy(by8));

  uart_rx_cfg #(.CLKS_PER_BIT(16), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .CNT_W(5)) u7 (
    .clk(clk), .rst_n(rst_n), .en(en), .rxIn(rx7), .rxAck(rxAck),
    .rxOut(out7), .rxValid(v7), .rxDone(d7), .parityErr(pe7), .frameErr(fe7),
    .breakDet(bk7), .overrun(ov7), .busy(by7));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts cycles with rxDone high, so a stretched pulse shows up as an extra completion.
  always @(posedge clk) begin
    if (d8) done8 <= done8 + 1;
    if (d7) done7 <= done7 + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached (actual running, required finished)");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int         sel;       // 0 = 8N1 instance, 1 = 7E2 instance
    logic [8:0] data;
    logic       par;
    logic       stop_lvl;
    int         spike;     // data bit index to spike at its centre, -1 for none
    logic [8:0] exp_out;
    logic       exp_pe;
    logic       exp_fe;
    logic       exp_bk;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic set_line(input int sel, input logic v);
    if (sel == 0) rx8 = v;
    else          rx7 = v;
  endtask

  task automatic send_frame(input int sel, input logic [8:0] data, input logic par,
                            input logic stop_lvl, input int spike, input int tail);
    int   nd;
    int   ns;
    int   total;
    logic b;
    nd    = (sel != 0) ? 7 : 8;
    ns    = (sel != 0) ? 2 : 1;
    total = 1 + nd + ((sel != 0) ? 1 : 0) + ns;
    for (int p = 0; p < total; p++) begin
      if (p == 0)                    b = 1'b0;
      else if (p <= nd)              b = data[p-1];
      else if (sel != 0 && p == nd+1) b = par;
      else                           b = stop_lvl;
      for (int j = 0; j < 16; j++) begin
        @(negedge clk);
        if (p >= 1 && p <= nd && (p - 1) == spike && j == 7) set_line(sel, ~b);
        else                                                 set_line(sel, b);
      end
    end
    for (int t = 0; t < tail; t++) begin
      @(negedge clk);
      set_line(sel, 1'b1);
    end
  endtask

  task automatic pulse_ack;
    @(negedge clk);
    rxAck = 1'b1;
    @(negedge clk);
    rxAck = 1'b0;
  endtask

  initial begin
    int          d0;
    int          busy_hi;
    logic [31:0] a_out;
    logic        a_v, a_pe, a_fe, a_bk, a_ov;

    vecs[0] = '{0, 9'h0A5, 1'b0, 1'b1, -1, 9'h0A5, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1, 9'h055, 1'b0, 1'b1, -1, 9'h055, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1, 9'h055, 1'b1, 1'b1, -1, 9'h055, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1, 9'h02A, 1'b1, 1'b1, -1, 9'h02A, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{0, 9'h03C, 1'b0, 1'b0, -1, 9'h03C, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{0, 9'h05A, 1'b0, 1'b1,  3, 9'h05A, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{0, 9'h00F, 1'b0, 1'b1,  6, 9'h00F, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0; en = 1'b1; rxAck = 1'b0; rx8 = 1'b1; rx7 = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out8", out8, 0);   chk("rst_valid8", v8, 0);  chk("rst_done8", d8, 0);
    chk("rst_busy8", by8, 0);   chk("rst_flags8", {pe8, fe8, bk8, ov8}, 0);
    chk("rst_out7", out7, 0);   chk("rst_valid7", v7, 0);  chk("rst_busy7", by7, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      d0 = (vecs[i].sel != 0) ? done7 : done8;
      send_frame(vecs[i].sel, vecs[i].data, vecs[i].par, vecs[i].stop_lvl, vecs[i].spike, 24);
      if (vecs[i].sel != 0) begin
        a_out = 32'(out7); a_v = v7; a_pe = pe7; a_fe = fe7; a_bk = bk7; a_ov = ov7;
        chk($sformatf("v%0d_done", i), done7 - d0, 1);
        chk($sformatf("v%0d_out", i), a_out, {25'd0, vecs[i].exp_out[6:0]});
      end else begin
        a_out = 32'(out8); a_v = v8; a_pe = pe8; a_fe = fe8; a_bk = bk8; a_ov = ov8;
        chk($sformatf("v%0d_done", i), done8 - d0, 1);
        chk($sformatf("v%0d_out", i), a_out, {24'd0, vecs[i].exp_out[7:0]});
      end
      chk($sformatf("v%0d_valid", i), a_v, 1);
      chk($sformatf("v%0d_perr", i), a_pe, vecs[i].exp_pe);
      chk($sformatf("v%0d_ferr", i), a_fe, vecs[i].exp_fe);
      chk($sformatf("v%0d_brk", i), a_bk, vecs[i].exp_bk);
      chk($sformatf("v%0d_ovr", i), a_ov, 0);
      pulse_ack();
      if (vecs[i].sel != 0) chk($sformatf("v%0d_ack_clr", i), {v7, pe7, fe7, bk7}, 0);
      else                  chk($sformatf("v%0d_ack_clr", i), {v8, pe8, fe8, bk8}, 0);
    end

    // Break: all-zero frame with a low stop bit, then the line stays low.
    d0 = done8;
    send_frame(0, 9'h000, 1'b0, 1'b0, -1, 0);
    busy_hi = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      rx8 = 1'b0;
      if (by8) busy_hi++;
    end
    chk("brk_done", done8 - d0, 1);
    chk("brk_out", out8, 8'h00);
    chk("brk_ferr", fe8, 1);
    chk("brk_det", bk8, 1);
    chk("brk_stuck_busy", busy_hi, 0);
    @(negedge clk); rx8 = 1'b1;
    repeat (20) @(negedge clk);
    pulse_ack();
    chk("brk_ack_clr", {v8, fe8, bk8}, 0);

    // Short low glitch on an idle line.
    d0 = done8;
    @(negedge clk); rx8 = 1'b0;
    repeat (4) @(negedge clk);
    rx8 = 1'b1;
    chk("glitch_busy_hi", by8, 1);
    repeat (20) @(negedge clk);
    chk("glitch_busy_lo", by8, 0);
    chk("glitch_nodone", done8 - d0, 0);
    chk("glitch_novalid", v8, 0);

    // Back-to-back frames without ack.
    d0 = done8;
    send_frame(0, 9'h011, 1'b0, 1'b1, -1, 0);
    send_frame(0, 9'h022, 1'b0, 1'b1, -1, 20);
    chk("ovr_done", done8 - d0, 2);
    chk("ovr_out", out8, 8'h22);
    chk("ovr_flag", ov8, 1);
    chk("ovr_valid", v8, 1);
    pulse_ack();
    chk("ovr_ack_clr", {v8, ov8}, 0);

    // Same, with ack landing in the second completion cycle.
    d0 = done8;
    send_frame(0, 9'h011, 1'b0, 1'b1, -1, 0);
    fork
      send_frame(0, 9'h022, 1'b0, 1'b1, -1, 20);
      begin
        repeat (155) @(negedge clk);
        rxAck = 1'b1;
        @(negedge clk);
        rxAck = 1'b0;
      end
    join
    chk("ackov_done", done8 - d0, 2);
    chk("ackov_out", out8, 8'h22);
    chk("ackov_flag", ov8, 0);
    chk("ackov_valid", v8, 1);
    pulse_ack();

    // Enable dropped mid-data.
    d0 = done8;
    fork
      send_frame(0, 9'h07E, 1'b0, 1'b1, -1, 20);
      begin
        repeat (60) @(negedge clk);
        chk("abort_busy_pre", by8, 1);
        en = 1'b0;
        @(negedge clk);
        chk("abort_busy_post", by8, 0);
      end
    join
    chk("abort_nodone", done8 - d0, 0);
    chk("abort_out_held", out8, 8'h22);
    chk("abort_novalid", v8, 0);
    en = 1'b1;
    repeat (5) @(negedge clk);

    // Reset asserted mid-frame.
    fork
      send_frame(0, 9'h07E, 1'b0, 1'b1, -1, 20);
      begin
        repeat (60) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_out", out8, 8'h00);
        chk("midrst_busy", by8, 0);
        chk("midrst_ctl", {v8, d8, pe8, fe8, bk8, ov8}, 0);
      end
    join
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    d0 = done8;
    send_frame(0, 9'h081, 1'b0, 1'b1, -1, 20);
    chk("post_done", done8 - d0, 1);
    chk("post_out", out8, 8'h81);
    chk("post_valid", v8, 1);
    chk("post_flags", {pe8, fe8, bk8, ov8}, 0);
    pulse_ack();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
